// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx serializer.
// Frame length depends on whether PISO_TX_PARITY_EN is defined.
package piso_tx_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
    localparam logic [1:0] ST_PARITY_ENC = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE_ENC,
        StShift  = ST_SHIFT_ENC,
        StParity = ST_PARITY_ENC
    } state_e;

    // Serial cycles per word: data bits plus the optional parity bit.
    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        return width + (parity_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with frame/last strobes and back-to-back words.
// Define PISO_TX_PARITY_EN to append one even-parity bit per word.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_bar,
    output logic             frame,
    output logic             last
);

    localparam int unsigned   CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CntPenult = CW'(WIDTH - 2);
`ifdef PISO_TX_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_bar_q, sout_bar_d;
    logic             frame_q, frame_d;
    logic             last_q, last_d;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             next_bit;
    logic             load_bit;
    logic [WIDTH-1:0] shreg_adv;
    logic [WIDTH-1:0] load_shreg;

    // A new word may load while the final bit of the current one is on the line.
    assign din_ready = rst_n & ((state_q == StIdle) | last_q);
    assign accept    = din_valid & din_ready;

    // The shifter always presents the next bit at the outgoing end.
    assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_adv  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    assign load_bit   = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign load_shreg = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sout_d   = 1'b0;
        frame_d  = 1'b0;
        last_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
            end
            StShift: begin
                if (cnt_q != CntLast) begin
                    sout_d  = next_bit;
                    shreg_d = shreg_adv;
                    cnt_d   = cnt_q + CW'(1);
                    frame_d = 1'b1;
                    last_d  = (cnt_q == CntPenult) && !ParityEn;
                end else begin
`ifdef PISO_TX_PARITY_EN
                    state_d = StParity;
                    sout_d  = parity_q;
                    frame_d = 1'b1;
                    last_d  = 1'b1;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            StParity: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // Loading overrides the end-of-word return to idle, giving gapless frames.
        if (accept) begin
            state_d  = StShift;
            shreg_d  = load_shreg;
            cnt_d    = '0;
            sout_d   = load_bit;
            frame_d  = 1'b1;
            last_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_d = ^din;
`endif
        end

        sout_bar_d = ~sout_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            sout_q     <= 1'b0;
            sout_bar_q <= 1'b1;
            frame_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            sout_q     <= sout_d;
            sout_bar_q <= sout_bar_d;
            frame_q    <= frame_d;
            last_q     <= last_d;
`ifdef PISO_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign sout     = sout_q;
    assign sout_bar = sout_bar_q;
    assign frame    = frame_q;
    assign last     = last_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first and LSB-first instances against a word-level model.
// Honours PISO_TX_PARITY_EN the same way the design does.
module tb_piso_tx;
    import piso_tx_pkg::*;

    localparam int unsigned W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned FL = frame_len(W, PAR);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] m_din = '0;
    logic         m_valid = 1'b0;
    logic         m_ready, m_sout, m_sout_bar, m_frame, m_last;
    logic [W-1:0] l_din = '0;
    logic         l_valid = 1'b0;
    logic         l_ready, l_sout, l_sout_bar, l_frame, l_last;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(m_din), .din_valid(m_valid), .din_ready(m_ready),
        .sout(m_sout), .sout_bar(m_sout_bar), .frame(m_frame), .last(m_last)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
        .sout(l_sout), .sout_bar(l_sout_bar), .frame(l_frame), .last(l_last)
    );

    // Observation vector: {sout, sout_bar, frame, last, din_ready}
    wire [4:0] m_obs = {m_sout, m_sout_bar, m_frame, m_last, m_ready};
    wire [4:0] l_obs = {l_sout, l_sout_bar, l_frame, l_last, l_ready};

    // k-th serial cycle of a word: data bits in the chosen order, then even parity.
    function automatic logic model_bit(input logic [W-1:0] w, input int k, input bit msb);
        if (k >= int'(W)) return ^w;
        return msb ? w[W-1-k] : w[k];
    endfunction

    function automatic logic [4:0] model_obs(input logic [W-1:0] w, input int k, input bit msb);
        logic b;
        logic fin;
        b   = model_bit(w, k, msb);
        fin = (k == int'(FL) - 1);
        return {b, ~b, 1'b1, fin, fin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_valid = 1'b0;
        l_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (m_obs !== 5'b01000) begin
            miscompares++;
            $display("FAIL reset_msb got %b want %b", m_obs, 5'b01000);
        end
        vectors++;
        if (l_obs !== 5'b01000) begin
            miscompares++;
            $display("FAIL reset_lsb got %b want %b", l_obs, 5'b01000);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset got %b want 1", m_ready);
        end
    endtask

    task automatic test_word(input logic [W-1:0] w, input string name);
        m_din = w;
        m_valid = 1'b1;
        vectors++;
        if (m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_idle got %b want 1", name, m_ready);
        end
        tick();
        m_valid = 1'b0;
        m_din = W'($urandom);
        for (int k = 0; k < int'(FL); k++) begin
            vectors++;
            if (m_obs !== model_obs(w, k, 1'b1)) begin
                miscompares++;
                $display("FAIL %s word=%h k=%0d got %b want %b", name, w, k, m_obs,
                         model_obs(w, k, 1'b1));
            end
            tick();
        end
        vectors++;
        if (m_obs !== 5'b01001) begin
            miscompares++;
            $display("FAIL %s idle_after got %b want %b", name, m_obs, 5'b01001);
        end
    endtask

    task automatic test_lsb(input logic [W-1:0] w);
        l_din = w;
        l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int k = 0; k < int'(FL); k++) begin
            vectors++;
            if (l_obs !== model_obs(w, k, 1'b0)) begin
                miscompares++;
                $display("FAIL lsb word=%h k=%0d got %b want %b", w, k, l_obs,
                         model_obs(w, k, 1'b0));
            end
            tick();
        end
        vectors++;
        if (l_obs !== 5'b01001) begin
            miscompares++;
            $display("FAIL lsb idle_after got %b want %b", l_obs, 5'b01001);
        end
    endtask

    task automatic test_back_to_back(input logic [W-1:0] w0, input logic [W-1:0] w1);
        int frames;
        frames = 0;
        m_din = w0;
        m_valid = 1'b1;
        tick();
        m_din = w1;
        for (int k = 0; k < 2 * int'(FL); k++) begin
            if (k == int'(FL)) m_valid = 1'b0;
            vectors++;
            if (m_obs !== model_obs((k < int'(FL)) ? w0 : w1, k % int'(FL), 1'b1)) begin
                miscompares++;
                $display("FAIL b2b k=%0d got %b want %b", k, m_obs,
                         model_obs((k < int'(FL)) ? w0 : w1, k % int'(FL), 1'b1));
            end
            if (m_frame === 1'b1) frames++;
            tick();
        end
        vectors++;
        if (frames !== 2 * int'(FL) || m_frame !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b frame_run got %0d/%b want %0d/0", frames, m_frame, 2 * FL);
        end
    endtask

    task automatic test_stall(input logic [W-1:0] w);
        m_din = w;
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int k = 0; k < int'(FL); k++) begin
            if (k == 4) m_valid = 1'b0;
            vectors++;
            if (m_obs !== model_obs(w, k, 1'b1)) begin
                miscompares++;
                $display("FAIL stall k=%0d got %b want %b", k, m_obs, model_obs(w, k, 1'b1));
            end
            if (k == 3) begin
                m_din = 8'hFF;
                m_valid = 1'b1;
            end
            tick();
        end
        vectors++;
        if (m_obs !== 5'b01001) begin
            miscompares++;
            $display("FAIL stall idle_after got %b want %b", m_obs, 5'b01001);
        end
    endtask

    task automatic test_reset_mid(input logic [W-1:0] w, input logic [W-1:0] w2);
        m_din = w;
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            vectors++;
            if (m_obs !== model_obs(w, k, 1'b1)) begin
                miscompares++;
                $display("FAIL rstmid pre k=%0d got %b want %b", k, m_obs, model_obs(w, k, 1'b1));
            end
            if (k < 4) tick();
        end
        rst_n = 1'b0;
        m_valid = 1'b1;
        #1;
        vectors++;
        if (m_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid ready_low got %b want 0", m_ready);
        end
        tick();
        vectors++;
        if (m_obs !== 5'b01000) begin
            miscompares++;
            $display("FAIL rstmid outputs got %b want %b", m_obs, 5'b01000);
        end
        m_valid = 1'b0;
        tick();
        vectors++;
        if (m_obs !== 5'b01000) begin
            miscompares++;
            $display("FAIL rstmid held got %b want %b", m_obs, 5'b01000);
        end
        rst_n = 1'b1;
        #1;
        test_word(w2, "after_reset");
    endtask

    initial begin
        test_reset();
        test_word(8'hA5, "a5");
        test_word(8'h07, "07");
        test_lsb(8'h01);
        for (int i = 0; i < 6; i++) begin
            test_word(W'($urandom), "rand_msb");
            test_lsb(W'($urandom));
        end
        test_back_to_back(8'hA5, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            test_back_to_back(W'($urandom), W'($urandom));
        end
        test_stall(W'($urandom));
        test_reset_mid(W'($urandom), W'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
